// File: rtl/pipeline_pkg.sv
// Shared definitions for the 5-stage 16-bit core pipeline control.
//   - state_e   : sequencer states (RUN, DRAIN, HALTED)
//   - REG_AW    : register-index width (16 registers)
//   - R0_IDX    : index of the hard-wired zero register
//   - NOP_INSTR : instruction word loaded by the IF/ID flush and ID/EX bubble paths
package pipeline_pkg;

  localparam int unsigned REG_AW    = 4;
  localparam int unsigned R0_IDX    = 0;
  localparam logic [15:0] NOP_INSTR = 16'h0000;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the pipeline performance counters.
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-low reset (clears count)
//   inc   - add one on the next edge unless already all-ones
//   clear - synchronous clear, wins over inc
//   count - current counter value (registered)
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_r;

  // Counter register: clears, or increments until all-ones and then holds.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (inc && (count_r != '1)) begin
      count_r <= count_r + WIDTH'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central pipeline sequencer: drives write-enable / flush / bubble controls of
// the PC and the IF/ID, ID/EX, EX/MEM, MEM/WB registers, resolving load-use
// hazards, taken-branch flushes, memory-busy stalls and HLT drain.
// Ports:
//   clk, rst                    - clock, asynchronous active-low reset
//   id_rs, id_rt, id_uses_rs/rt - source operands of the instruction in ID
//   idex_memread, idex_rd       - load-in-EX indicator and its destination
//   id_branch_taken, id_halt    - branch resolved taken / HLT present in ID
//   imem_busy, dmem_busy        - memory wait indications
//   pc_we .. memwb_we           - pipeline register write enables (combinational)
//   ifid_flush, idex_bubble     - NOP insertion controls (combinational)
//   halted                      - core stopped (registered)
//   stall_cnt, flush_cnt        - saturating performance counters (registered)
module pipeline_hazard_ctrl #(
  parameter int unsigned REG_AW       = pipeline_pkg::REG_AW,
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              idex_memread,
  input  logic [REG_AW-1:0] idex_rd,
  input  logic              id_branch_taken,
  input  logic              id_halt,
  input  logic              imem_busy,
  input  logic              dmem_busy,
  output logic              pc_we,
  output logic              ifid_we,
  output logic              idex_we,
  output logic              exmem_we,
  output logic              memwb_we,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  import pipeline_pkg::state_e;
  import pipeline_pkg::RUN;
  import pipeline_pkg::DRAIN;
  import pipeline_pkg::HALTED;
  import pipeline_pkg::R0_IDX;

  localparam int unsigned DW = $clog2(DRAIN_CYCLES + 1);

  state_e        state_r;
  state_e        state_nxt_s;
  logic [DW-1:0] drain_cnt_r;
  logic [DW-1:0] drain_nxt_s;
  logic          halted_r;
  logic          load_use_s;
  logic          halt_accept_s;
  logic          stall_inc_s;
  logic          flush_inc_s;

  // Load-use detection; writes to R0 never create a dependency.
  always_comb begin
    load_use_s = idex_memread && (idex_rd != REG_AW'(R0_IDX)) &&
                 ((id_uses_rs && (id_rs == idex_rd)) ||
                  (id_uses_rt && (id_rt == idex_rd)));
  end

  // HLT only counts when no higher-priority cause is active in the same cycle.
  always_comb begin
    halt_accept_s = id_halt && !dmem_busy && !load_use_s &&
                    !id_branch_taken && !imem_busy;
  end

  // State, drain counter and halted flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= RUN;
      drain_cnt_r <= '0;
      halted_r    <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      drain_cnt_r <= drain_nxt_s;
      halted_r    <= (state_nxt_s == HALTED);
    end
  end

  // Next-state logic; DRAIN counts only non-frozen cycles.
  always_comb begin
    state_nxt_s = state_r;
    drain_nxt_s = drain_cnt_r;
    case (state_r)
      RUN: begin
        if (halt_accept_s) begin
          state_nxt_s = DRAIN;
          drain_nxt_s = DW'(DRAIN_CYCLES);
        end else begin
          state_nxt_s = RUN;
        end
      end
      DRAIN: begin
        if (dmem_busy) begin
          state_nxt_s = DRAIN;
        end else if (drain_cnt_r <= DW'(1)) begin
          state_nxt_s = HALTED;
          drain_nxt_s = '0;
        end else begin
          state_nxt_s = DRAIN;
          drain_nxt_s = drain_cnt_r - DW'(1);
        end
      end
      HALTED: begin
        state_nxt_s = HALTED;
      end
      default: begin
        state_nxt_s = RUN;
        drain_nxt_s = '0;
      end
    endcase
  end

  // Pipeline control outputs; forced to a safe all-NOP pattern during reset.
  always_comb begin
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    idex_we     = 1'b1;
    exmem_we    = 1'b1;
    memwb_we    = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (!rst) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_we     = 1'b0;
      exmem_we    = 1'b0;
      memwb_we    = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else begin
      case (state_r)
        RUN: begin
          if (dmem_busy) begin
            pc_we    = 1'b0;
            ifid_we  = 1'b0;
            idex_we  = 1'b0;
            exmem_we = 1'b0;
            memwb_we = 1'b0;
          end else if (load_use_s) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
          end else if (id_branch_taken) begin
            // PC keeps loading: the branch target wins over imem_busy.
            ifid_flush = 1'b1;
          end else if (imem_busy) begin
            pc_we      = 1'b0;
            ifid_flush = 1'b1;
          end else begin
            pc_we = 1'b1;
          end
        end
        DRAIN: begin
          pc_we      = 1'b0;
          ifid_flush = 1'b1;
          if (dmem_busy) begin
            ifid_we  = 1'b0;
            idex_we  = 1'b0;
            exmem_we = 1'b0;
            memwb_we = 1'b0;
          end else begin
            ifid_we = 1'b1;
          end
        end
        HALTED: begin
          pc_we    = 1'b0;
          ifid_we  = 1'b0;
          idex_we  = 1'b0;
          exmem_we = 1'b0;
          memwb_we = 1'b0;
        end
        default: begin
          pc_we    = 1'b0;
          ifid_we  = 1'b0;
          idex_we  = 1'b0;
          exmem_we = 1'b0;
          memwb_we = 1'b0;
        end
      endcase
    end
  end

  // Counter qualifiers; DRAIN's own pc_we=0 is not a stall, only dmem_busy is.
  always_comb begin
    stall_inc_s = 1'b0;
    flush_inc_s = 1'b0;
    case (state_r)
      RUN: begin
        stall_inc_s = dmem_busy || load_use_s || (imem_busy && !id_branch_taken);
        flush_inc_s = !dmem_busy && !load_use_s && id_branch_taken;
      end
      DRAIN: begin
        stall_inc_s = dmem_busy;
        flush_inc_s = 1'b0;
      end
      default: begin
        stall_inc_s = 1'b0;
        flush_inc_s = 1'b0;
      end
    endcase
  end

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc_s),
    .clear (1'b0),
    .count (stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_inc_s),
    .clear (1'b0),
    .count (flush_cnt)
  );

  assign halted = halted_r;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  localparam int DRAIN_N = 3;
  localparam int CNT_MAX = 65535;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  id_rs = 4'd0, id_rt = 4'd0, idex_rd = 4'd0;
  logic        id_uses_rs = 1'b0, id_uses_rt = 1'b0, idex_memread = 1'b0;
  logic        id_branch_taken = 1'b0, id_halt = 1'b0;
  logic        imem_busy = 1'b0, dmem_busy = 1'b0;
  logic        pc_we, ifid_we, idex_we, exmem_we, memwb_we;
  logic        ifid_flush, idex_bubble, halted;
  logic [15:0] stall_cnt, flush_cnt;

  int checks = 0;
  int failures = 0;

  // Reference model: plain flags and integer counts.
  bit m_draining, m_halted;
  int m_left, m_stall, m_flush;

  pipeline_hazard_ctrl #(.REG_AW(4), .DRAIN_CYCLES(DRAIN_N), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .idex_memread(idex_memread), .idex_rd(idex_rd),
    .id_branch_taken(id_branch_taken), .id_halt(id_halt),
    .imem_busy(imem_busy), .dmem_busy(dmem_busy),
    .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we),
    .exmem_we(exmem_we), .memwb_we(memwb_we),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_load_use();
    return idex_memread && (idex_rd != 4'd0) &&
           ((id_uses_rs && id_rs == idex_rd) || (id_uses_rt && id_rt == idex_rd));
  endfunction

  task automatic set_quiet();
    id_rs = 4'd0; id_rt = 4'd0; idex_rd = 4'd0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; idex_memread = 1'b0;
    id_branch_taken = 1'b0; id_halt = 1'b0; imem_busy = 1'b0; dmem_busy = 1'b0;
  endtask

  // Asynchronous reset pulse starting #1 after a rising edge.
  task automatic do_reset();
    rst = 1'b0;
    #2;
    check("rst_we", {pc_we, ifid_we, idex_we, exmem_we, memwb_we}, 5'b00000);
    check("rst_flush_bubble", {ifid_flush, idex_bubble}, 2'b11);
    check("rst_halted", halted, 1'b0);
    check("rst_stall_cnt", stall_cnt, 16'd0);
    check("rst_flush_cnt", flush_cnt, 16'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    m_draining = 1'b0; m_halted = 1'b0; m_left = 0; m_stall = 0; m_flush = 0;
  endtask

  // One clock cycle with the currently driven inputs, checked against the model.
  task automatic run_cycle(input bit do_check);
    bit lu, e_pc, e_ifid, e_back, e_flush, e_bub, st_ev, fl_ev;
    @(negedge clk);
    lu = ref_load_use();
    e_pc = 1; e_ifid = 1; e_back = 1; e_flush = 0; e_bub = 0; st_ev = 0; fl_ev = 0;
    if (m_halted) begin
      e_pc = 0; e_ifid = 0; e_back = 0;
    end else if (m_draining) begin
      e_pc = 0; e_flush = 1;
      if (dmem_busy) begin e_ifid = 0; e_back = 0; st_ev = 1; end
    end else if (dmem_busy) begin
      e_pc = 0; e_ifid = 0; e_back = 0; st_ev = 1;
    end else if (lu) begin
      e_pc = 0; e_ifid = 0; e_bub = 1; st_ev = 1;
    end else if (id_branch_taken) begin
      e_flush = 1; fl_ev = 1;
    end else if (imem_busy) begin
      e_pc = 0; e_flush = 1; st_ev = 1;
    end
    if (do_check) begin
      check("pc_we", pc_we, e_pc);
      check("ifid_we", ifid_we, e_ifid);
      check("back_we", {idex_we, exmem_we, memwb_we}, {3{e_back}});
      check("ifid_flush", ifid_flush, e_flush);
      check("idex_bubble", idex_bubble, e_bub);
      check("halted", halted, m_halted);
      check("stall_cnt", stall_cnt, m_stall);
      check("flush_cnt", flush_cnt, m_flush);
    end
    @(posedge clk); #1;
    if (st_ev && m_stall < CNT_MAX) m_stall++;
    if (fl_ev && m_flush < CNT_MAX) m_flush++;
    if (m_draining && !dmem_busy) begin
      m_left--;
      if (m_left == 0) begin m_draining = 0; m_halted = 1; end
    end else if (!m_draining && !m_halted && id_halt && !dmem_busy && !lu &&
                 !id_branch_taken && !imem_busy) begin
      m_draining = 1; m_left = DRAIN_N;
    end
  endtask

  initial begin
    #1;
    set_quiet();
    do_reset();

    // Reset state with quiet inputs: everything advances.
    run_cycle(1'b1);

    // Load-use on rs, then the same with rd=R0.
    idex_memread = 1; idex_rd = 4'd5; id_rs = 4'd5; id_uses_rs = 1;
    run_cycle(1'b1);
    check("lu_stall_cnt", stall_cnt, 16'd1);
    idex_rd = 4'd0; id_rs = 4'd0;
    run_cycle(1'b1);
    check("lu_r0_stall_cnt", stall_cnt, 16'd1);
    set_quiet();

    // Branch and imem_busy together: branch wins, PC loads target.
    id_branch_taken = 1; imem_busy = 1;
    run_cycle(1'b1);
    check("br_flush_cnt", flush_cnt, 16'd1);
    check("br_stall_cnt", stall_cnt, 16'd1);
    set_quiet();

    // dmem_busy with load_use for 3 cycles: freeze, no bubble.
    do_reset();
    idex_memread = 1; idex_rd = 4'd7; id_rt = 4'd7; id_uses_rt = 1; dmem_busy = 1;
    repeat (3) run_cycle(1'b1);
    check("frz_stall_cnt", stall_cnt, 16'd3);
    set_quiet();

    // HLT with one frozen cycle inside DRAIN: halted on the 5th edge.
    do_reset();
    id_halt = 1;
    run_cycle(1'b1);
    id_halt = 0;
    run_cycle(1'b1);
    dmem_busy = 1;
    run_cycle(1'b1);
    dmem_busy = 0;
    run_cycle(1'b1);
    check("hlt_not_yet", halted, 1'b0);
    run_cycle(1'b1);
    check("hlt_halted", halted, 1'b1);
    check("hlt_stall_cnt", stall_cnt, 16'd1);
    idex_memread = 1; idex_rd = 4'd3; id_rs = 4'd3; id_uses_rs = 1; id_branch_taken = 1;
    run_cycle(1'b1);
    check("hlt_we_off", {pc_we, ifid_we, idex_we, exmem_we, memwb_we}, 5'b00000);
    set_quiet();

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      id_rs = 4'($urandom_range(0, 3));
      id_rt = 4'($urandom_range(0, 3));
      idex_rd = 4'($urandom_range(0, 3));
      id_uses_rs = 1'($urandom_range(0, 1));
      id_uses_rt = 1'($urandom_range(0, 1));
      idex_memread = ($urandom_range(0, 2) == 0);
      id_branch_taken = ($urandom_range(0, 5) == 0);
      imem_busy = ($urandom_range(0, 4) == 0);
      dmem_busy = ($urandom_range(0, 5) == 0);
      id_halt = ($urandom_range(0, 29) == 0);
      run_cycle(1'b1);
      if (m_halted && $urandom_range(0, 3) == 0) do_reset();
    end
    set_quiet();

    // Saturation: 70000 frozen cycles, then HLT and reset mid-DRAIN.
    do_reset();
    dmem_busy = 1;
    for (int i = 0; i < 70000; i++) run_cycle(1'b0);
    check("sat_stall_cnt", stall_cnt, 16'hFFFF);
    run_cycle(1'b1);
    check("sat_hold", stall_cnt, 16'hFFFF);
    dmem_busy = 0; id_halt = 1;
    run_cycle(1'b1);
    id_halt = 0;
    run_cycle(1'b1);
    check("drain_pc_we", pc_we, 1'b0);
    do_reset();
    run_cycle(1'b1);
    check("post_rst_pc_we", pc_we, 1'b1);
    check("post_rst_stall_cnt", stall_cnt, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
